bhg_fifo_rr_arbiter: RTL and testbench
======================================

# bhg_fifo_rr_arbiter

Round-robin arbiter that drains up to PORTS first-word-fall-through requester FIFOs into one shared downstream FIFO input, for example the DDR3 command queue. Each grant holds for a bounded burst of words, then rotates to the next ready port. The block sits between the per-requester FWFT shifter FIFOs and the single controller-side FIFO. It tags every forwarded word with its source port.

## Interface
- PORTS, 4: number of requester FIFOs, 2..16.
- bits, 8: data word width.
- max_burst, 4: maximum words forwarded per grant, 1..255.
- clk  in  1: single clock, rising edge.
- reset_n  in  1: asynchronous, active-low reset. Release is synchronised externally.
- port_ready  in  PORTS: data_ready of each requester FIFO.
- port_data  in  PORTS x bits: data_out of each requester FIFO.
- port_shift_out  out  PORTS: shift_out to each requester FIFO (pop). Combinational, one-hot or zero.
- out_full  in  1: full flag of the downstream FIFO. The downstream FIFO must be built with spare_words >= 1.
- out_shift_in  out  1: registered shift_in to the downstream FIFO.
- out_data  out  bits: registered data to the downstream FIFO.
- out_port  out  PORT_BITS: registered source-port tag of out_data.
- busy  out  1: high while state is GRANT.

## Operation
- PORT_BITS = max(1, $clog2(PORTS)). burst_cnt is $clog2(max_burst+1) bits wide.
- States: IDLE and GRANT. Registers: gnt[PORT_BITS], last_gnt[PORT_BITS], burst_cnt.
- IDLE:
  - If any port_ready bit is set, select the first ready port searching from last_gnt+1 upward, wrapping at PORTS-1 to 0.
  - Load gnt with that port, clear burst_cnt, and go to GRANT.
  - With no ready port, stay in IDLE.
- GRANT:
  - pop = port_ready[gnt] && !out_full.
  - port_shift_out[gnt] = pop. All other bits are 0. In IDLE, all bits are 0.
  - On pop, burst_cnt increments.
- Release from GRANT to IDLE with last_gnt <= gnt when either condition holds:
  - pop and burst_cnt == max_burst-1, or
  - !port_ready[gnt] (port drained).
- When out_full is high and port_ready[gnt] is high, hold GRANT. No pop occurs and burst_cnt holds.
- Output register, every cycle:
  - out_shift_in <= pop.
  - On pop, out_data <= port_data[gnt] and out_port <= gnt. Otherwise both hold.
- Reset values: state IDLE, gnt 0, last_gnt PORTS-1 (so port 0 wins first), burst_cnt 0, out_shift_in 0, out_data 0, out_port 0, busy 0.
- Reset asserted mid-burst: all registers return to reset values immediately. port_shift_out drops to 0 in the same cycle, and no word is lost from a requester.
- Ports with index >= PORTS do not exist; there is no masking requirement.

## Timing
- Latency from port_ready rising (port idle) to first word:
  - 1 cycle arbitration in IDLE.
  - Pop in the first GRANT cycle.
  - out_shift_in high on the following cycle.
  - Total: 2 cycles from the ready edge to out_shift_in.
- Sustained throughput is 1 word per cycle within a burst.
- Each release costs exactly one IDLE cycle before the next grant.
- out_full is sampled combinationally in the pop cycle. Because out_shift_in lags pop by one cycle, the downstream FIFO absorbs at most one word after asserting full, which spare_words >= 1 covers.
- Fairness: a continuously ready port is served at least once every PORTS grants.

## Structure
- Package bhg_fifo_arb_pkg holds:
  - state enum {IDLE, GRANT};
  - function port_bits(PORTS);
  - function rr_next(ready vector, last_gnt) returning the next index.
- One combinational sub-module, bhg_rr_pick. Inputs: ready vector and last index. Outputs: found flag and selected index. It is instantiated once, in IDLE-path logic.

## Test plan
- Single port: port 2 ready with 3 words 0xA1, 0xA2, 0xA3, out_full 0 → pops in cycles 1-3, out_shift_in in cycles 2-4, out_port = 2 each time, then return to IDLE.
- Burst cap: PORTS=4, max_burst=4, ports 0 and 1 each ready with 10 words → forwarded order is 0×4, 1×4, 0×4, 1×4, 0×2, 1×2, with one idle cycle between grants.
- Backpressure: out_full high for 5 cycles mid-burst → no pop, burst_cnt frozen, GRANT held; the burst resumes at the same word after full drops, and no word is duplicated or dropped.
- Wrap-around: last_gnt = 3, ports 0 and 3 ready → port 0 granted next, then 3.
- Early drain: port 1 ready with 1 word, max_burst 4 → one word forwarded, release on !port_ready, next ready port granted two cycles after the release edge.
- Async reset mid-burst: reset_n low between clock edges → port_shift_out 0 and out_shift_in 0 immediately; after release, port 0 is served first.

Source files
------------

// File: rtl/bhg_fifo_rr_arbiter_pkg.sv
// bhg_fifo_arb_pkg: shared types and helpers for the round-robin FIFO arbiter.
package bhg_fifo_arb_pkg;

    typedef enum logic {IDLE, GRANT} state_t;

    function automatic int port_bits(input int ports);
        return ports > 2 ? $clog2(ports) : 1;
    endfunction

    // First ready index strictly after last, wrapping at ports-1; supports up to 16 ports.
    function automatic logic [3:0] rr_next(input logic [15:0] ready, input logic [3:0] last, input int ports);
        int idx;
        logic [3:0] r;
        logic hit;
        r = last;
        hit = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            idx = (int'(last) + i) % ports;
            if (i <= ports && !hit && ready[idx[3:0]]) begin
                r = idx[3:0];
                hit = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bhg_fifo_rr_arbiter_if.sv
// bhg_fifo_rr_arbiter_if: requester-side and downstream-side handshake bundle.
interface bhg_fifo_rr_arbiter_if #(parameter int PORTS = 4, parameter int bits = 8);
    import bhg_fifo_arb_pkg::*;
    localparam int PB = port_bits(PORTS);
    logic [PORTS-1:0] port_ready;
    logic [PORTS-1:0][bits-1:0] port_data;
    logic [PORTS-1:0] port_shift_out;
    logic out_full;
    logic out_shift_in;
    logic [bits-1:0] out_data;
    logic [PB-1:0] out_port;
    logic busy;
    modport master(input port_ready, port_data, out_full,
                   output port_shift_out, out_shift_in, out_data, out_port, busy);
    modport slave(output port_ready, port_data, out_full,
                  input port_shift_out, out_shift_in, out_data, out_port, busy);
endinterface

// File: rtl/bhg_fifo_rr_arbiter_pick.sv
// bhg_rr_pick: combinational round-robin selection of the next ready port.
module bhg_rr_pick
    import bhg_fifo_arb_pkg::*;
#(
    parameter int PORTS = 4,
    localparam int PB = port_bits(PORTS)
) (
    input  logic [PORTS-1:0] ready,
    input  logic [PB-1:0]    last,
    output logic             found,
    output logic [PB-1:0]    sel
);
    assign found = |ready;
    assign sel = PB'(rr_next(16'(ready), 4'(last), PORTS));
endmodule

// File: rtl/bhg_fifo_rr_arbiter.sv
// bhg_fifo_rr_arbiter: drains FWFT requester FIFOs round-robin into one downstream FIFO,
// bounded bursts per grant, each forwarded word tagged with its source port.
module bhg_fifo_rr_arbiter
    import bhg_fifo_arb_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int bits = 8,
    parameter int max_burst = 4
) (
    input logic clk,
    input logic reset_n,
    bhg_fifo_rr_arbiter_if.master bus
);
    localparam int PB = port_bits(PORTS);
    localparam int BW = $clog2(max_burst + 1);

    state_t state_q, state_d;
    logic [PB-1:0] gnt_q, gnt_d, last_gnt_q, last_gnt_d, out_port_q, out_port_d, sel;
    logic [BW-1:0] burst_q, burst_d;
    logic [bits-1:0] out_data_q, out_data_d;
    logic out_shift_in_q, out_shift_in_d;
    logic found, pop, rel;

    bhg_rr_pick #(.PORTS(PORTS)) u_pick (
        .ready(bus.port_ready),
        .last (last_gnt_q),
        .found(found),
        .sel  (sel)
    );

    // Pop depends on state_q, so an asserted reset kills it in the same cycle.
    assign pop = state_q == GRANT && bus.port_ready[gnt_q] && !bus.out_full;
    assign rel = (pop && burst_q == BW'(max_burst - 1)) || !bus.port_ready[gnt_q];

    always_comb begin
        state_d = state_q;
        gnt_d = gnt_q;
        last_gnt_d = last_gnt_q;
        burst_d = burst_q;
        if (state_q == IDLE) begin
            state_d = found ? GRANT : IDLE;
            gnt_d = found ? sel : gnt_q;
            burst_d = found ? '0 : burst_q;
        end else begin
            burst_d = pop ? burst_q + BW'(1) : burst_q;
            state_d = rel ? IDLE : GRANT;
            last_gnt_d = rel ? gnt_q : last_gnt_q;
        end
        out_shift_in_d = pop;
        out_data_d = pop ? bus.port_data[gnt_q] : out_data_q;
        out_port_d = pop ? gnt_q : out_port_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q <= '0;
            last_gnt_q <= PB'(PORTS - 1);
            burst_q <= '0;
            out_shift_in_q <= 1'b0;
            out_data_q <= '0;
            out_port_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            last_gnt_q <= last_gnt_d;
            burst_q <= burst_d;
            out_shift_in_q <= out_shift_in_d;
            out_data_q <= out_data_d;
            out_port_q <= out_port_d;
        end
    end

    assign bus.port_shift_out = pop ? PORTS'(1) << gnt_q : '0;
    assign bus.out_shift_in = out_shift_in_q;
    assign bus.out_data = out_data_q;
    assign bus.out_port = out_port_q;
    assign bus.busy = state_q == GRANT;
endmodule

// File: tb/tb_bhg_fifo_rr_arbiter.sv
// tb_bhg_fifo_rr_arbiter: random and directed stimulus checked against a queue-based
// model of the requester FIFOs and the round-robin grant rules.
module tb_bhg_fifo_rr_arbiter;
    localparam int P = 4;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    bhg_fifo_rr_arbiter_if #(.PORTS(P), .bits(8)) bus();
    bhg_fifo_rr_arbiter #(.PORTS(P), .bits(8), .max_burst(MB)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] q[P][$];
    int n_chk = 0, n_fail = 0, cyc = 0;
    int pushed[P], fwd[P], lost[P];
    int lp[$], ld[$], lc[$];
    int m_srv, m_cnt, m_last, e_port;
    bit e_si;
    logic [7:0] e_data;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int p, input logic [7:0] d);
        q[p].push_back(d);
        pushed[p]++;
    endtask

    task automatic model_reset();
        m_srv = -1;
        m_cnt = 0;
        m_last = P - 1;
        e_si = 0;
        e_data = 8'h00;
        e_port = 0;
    endtask

    task automatic clear_log();
        lp.delete();
        ld.delete();
        lc.delete();
    endtask

    task automatic drive(input bit full);
        bus.out_full = full;
        for (int p = 0; p < P; p++) begin
            bus.port_ready[p] = q[p].size() != 0;
            bus.port_data[p] = q[p].size() != 0 ? q[p][0] : 8'h00;
        end
    endtask

    // One clock: drive at negedge, compare against the model, then advance the model after posedge.
    task automatic step(input bit full);
        logic [P-1:0] rdy, ev;
        int pick;
        bit pop;
        @(negedge clk);
        cyc++;
        drive(full);
        rdy = bus.port_ready;
        pick = -1;
        pop = 0;
        if (m_srv < 0) begin
            for (int i = 1; i <= P; i++)
                if (pick < 0 && rdy[(m_last + i) % P]) pick = (m_last + i) % P;
        end else pop = rdy[m_srv] && !full;
        ev = '0;
        if (pop) ev[m_srv] = 1'b1;
        #1;
        chk("port_shift_out", int'(bus.port_shift_out), int'(ev));
        chk("out_shift_in", int'(bus.out_shift_in), int'(e_si));
        chk("out_data", int'(bus.out_data), int'(e_data));
        chk("out_port", int'(bus.out_port), e_port);
        chk("busy", int'(bus.busy), int'(m_srv >= 0));
        if (bus.out_shift_in) begin
            lp.push_back(int'(bus.out_port));
            ld.push_back(int'(bus.out_data));
            lc.push_back(cyc);
            fwd[bus.out_port]++;
        end
        @(posedge clk);
        #1;
        if (m_srv < 0) begin
            e_si = 0;
            if (pick >= 0) begin
                m_srv = pick;
                m_cnt = 0;
            end
        end else begin
            e_si = pop;
            if (pop) begin
                e_data = q[m_srv][0];
                e_port = m_srv;
                void'(q[m_srv].pop_front());
                m_cnt++;
            end
            if ((pop && m_cnt == MB) || !rdy[m_srv]) begin
                m_last = m_srv;
                m_srv = -1;
            end
        end
    endtask

    // Reset asserted between edges while port 2 is mid-burst.
    task automatic reset_mid();
        @(negedge clk);
        cyc++;
        drive(0);
        #1;
        chk("pre_rst_pso", int'(bus.port_shift_out), 4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_pso", int'(bus.port_shift_out), 0);
        chk("rst_si", int'(bus.out_shift_in), 0);
        chk("rst_busy", int'(bus.busy), 0);
        if (e_si) lost[e_port]++;
        model_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n0, idx, k;
        int pat[6] = '{4, 4, 4, 4, 2, 2};
        for (int p = 0; p < P; p++) begin
            pushed[p] = 0;
            fwd[p] = 0;
            lost[p] = 0;
        end
        model_reset();
        drive(0);
        repeat (2) @(negedge clk);
        #1;
        chk("reset_pso", int'(bus.port_shift_out), 0);
        chk("reset_si", int'(bus.out_shift_in), 0);
        chk("reset_data", int'(bus.out_data), 0);
        chk("reset_port", int'(bus.out_port), 0);
        chk("reset_busy", int'(bus.busy), 0);
        @(negedge clk);
        reset_n = 1'b1;

        clear_log();
        push(2, 8'hA1);
        push(2, 8'hA2);
        push(2, 8'hA3);
        n0 = cyc + 1;
        repeat (8) step(0);
        chk("sp_count", lp.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("sp_port", lp[i], 2);
            chk("sp_data", ld[i], 8'hA1 + i);
            chk("sp_cycle", lc[i], n0 + 2 + i);
        end

        clear_log();
        for (int i = 0; i < 10; i++) begin
            push(0, 8'(i));
            push(1, 8'(8'h10 + i));
        end
        repeat (40) step(0);
        chk("bc_count", lp.size(), 20);
        idx = 0;
        for (int g = 0; g < 6; g++)
            for (int j = 0; j < pat[g]; j++) begin
                chk("bc_port", lp[idx], g % 2);
                idx++;
            end
        for (int i = 1; i < 20; i++)
            chk("bc_gap", lc[i] - lc[i-1], i == 18 ? 3 : (i % 4 == 0 && i <= 16) ? 2 : 1);

        clear_log();
        for (int i = 0; i < 6; i++) push(0, 8'(8'hC0 + i));
        repeat (3) step(0);
        repeat (5) step(1);
        repeat (10) step(0);
        chk("bp_count", lp.size(), 6);
        for (int i = 0; i < 6; i++) chk("bp_data", ld[i], 8'hC0 + i);
        chk("bp_gap", lc[2] - lc[1], 6);

        clear_log();
        push(3, 8'hD0);
        repeat (5) step(0);
        push(0, 8'hE0);
        push(3, 8'hD1);
        repeat (8) step(0);
        chk("wrap_count", lp.size(), 3);
        chk("wrap_first", lp[0], 3);
        chk("wrap_second", lp[1], 0);
        chk("wrap_third", lp[2], 3);

        clear_log();
        push(1, 8'hF0);
        step(0);
        step(0);
        push(2, 8'hF1);
        repeat (6) step(0);
        chk("ed_count", lp.size(), 2);
        chk("ed_port0", lp[0], 1);
        chk("ed_port1", lp[1], 2);
        chk("ed_gap", lc[1] - lc[0], 3);

        clear_log();
        for (int i = 0; i < 6; i++) push(2, 8'(8'hB0 + i));
        repeat (3) step(0);
        reset_mid();
        push(0, 8'h90);
        push(0, 8'h91);
        repeat (25) step(0);
        chk("rm_count", lp.size(), 7);
        chk("rm_d0", ld[0], 8'hB0);
        chk("rm_p1", lp[1], 0);
        chk("rm_d1", ld[1], 8'h90);
        chk("rm_d2", ld[2], 8'h91);
        chk("rm_d3", ld[3], 8'hB2);

        for (int i = 0; i < 3000; i++) begin
            step($urandom % 4 == 0);
            if ($urandom % 2 == 0) push(int'($urandom % P), 8'($urandom));
        end
        k = 0;
        while ((q[0].size() + q[1].size() + q[2].size() + q[3].size() != 0 || m_srv >= 0) && k < 200) begin
            step(0);
            k++;
        end
        repeat (3) step(0);
        chk("drain_in_time", int'(k < 200), 1);
        for (int p = 0; p < P; p++) chk("words_accounted", fwd[p] + lost[p], pushed[p]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
